display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Shares the single 3-digit seven-segment display driver between two content sources: A, typically the rotating-square animation, and B, a status/counter source.
- Round-robin arbitration with a maximum tenure measured in frame ticks from the frequency divider.
- Inserts a blanked gap between owners.
- Sits between the sources and the hex mux; its hex2/hex1/hex0/dp/digit_en outputs feed the mux directly.

Parameters:
- MAX_TICKS, 16: tenure limit in ticks. The owner is preempted once it reaches this limit while the other source requests. Must be >= 1.
- GAP_TICKS, 2: number of blank ticks between owner changes. Must be >= 1.
- CNT_W, 5: width of the tenure and gap counters. Must satisfy 2^CNT_W > max(MAX_TICKS, GAP_TICKS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide frame tick from the frequency divider.
- req  in  2  request: bit0 = A, bit1 = B. Level-sensitive.
- a_hex2, a_hex1, a_hex0  in  5 each  source A digit codes.
- a_dp  in  3  source A decimal points.
- b_hex2, b_hex1, b_hex0  in  5 each  source B digit codes.
- b_dp  in  3  source B decimal points.
- gnt  out  2  one-hot grant (bit0 = A, bit1 = B), or 00.
- hex2, hex1, hex0  out  5 each  digit codes to the hex mux.
- dp  out  3  decimal points to the mux.
- digit_en  out  3  per-digit enable; 1 = lit.
- busy  out  1  high in OWN or GAP.

Behaviour:
- Reset (synchronous, has priority over everything):
  - state = IDLE; gnt = 00; hex* = 0; dp = 000; digit_en = 000; busy = 0.
  - tenure and gap counters = 0; last_owner = B, so A wins the first contention.
- IDLE:
  - If req == 00, stay in IDLE.
  - If exactly one request bit is set, grant that source.
  - If req == 11, grant the source that is not last_owner.
  - The grant moves to OWN on the next clk edge, independent of tick; tenure counter is cleared and last_owner is set to the new owner.
- OWN:
  - Tenure counter increments on each tick and saturates at MAX_TICKS.
  - Release: if the owner's req bit is low at a clk edge, go to GAP. This is immediate and does not wait for a tick.
  - Preempt: if the other req bit is high and tenure == MAX_TICKS, go to GAP.
  - Release and preempt true on the same edge: go to GAP; the next owner is resolved at the end of GAP.
  - Owner requests and the other source does not: stay in OWN indefinitely; the counter stays saturated.
- GAP:
  - gnt = 00 and outputs are blanked.
  - Gap counter is cleared on entry and increments on tick.
  - When gap counter == GAP_TICKS: evaluate req using the IDLE rules (round-robin against last_owner). If req == 00, go to IDLE.
  - If the previous owner is the only requester at gap end, it is re-granted with its tenure counter cleared.
- Output data path (registered, 1-clk latency):
  - In OWN, each clk captures the owner's hex2/1/0 and dp, and digit_en = 111.
  - In IDLE or GAP, each clk drives hex* = 0, dp = 000, digit_en = 000.
  - gnt and busy are registered state decodes. gnt changes on the same edge as the state; data outputs follow one clk later.
  - A source change is therefore always separated by at least GAP_TICKS ticks of blank display. No clk ever shows a mixture of digits from A and B.
- Tick behaviour:
  - tick asserted on the same edge as a state transition counts only in the new state if that state counts ticks. Counters are cleared on entry, and the tick is applied after the clear.
  - tick in IDLE is ignored.
- Reset mid-OWN or mid-GAP: on the next edge, outputs blank, gnt = 00, and last_owner returns to B.
- req changes during GAP take effect only at gap end.
- Inputs of the non-owner are never sampled.

Test Plan:
- Reset, then req = 01: gnt = 01 after 1 clk. digit_en = 111 and hex* = a_hex* after 2 clks. Change a_hex0 from 3 to 7: hex0 = 7 one clk later.
- req = 11 from IDLE after reset: A granted. Hold req = 11 for 16 ticks (MAX_TICKS = 16): gnt drops to 00 and digit_en = 000 for exactly 2 ticks. Then gnt = 10 and hex* = b_hex*.
- A owns with req = 01; drop req to 00 mid-tenure between ticks: next edge gnt = 00. After 2 ticks, state = IDLE and busy = 0.
- A owns for 40 ticks with B idle: no preemption, gnt stays 01. Raise req[1] at tick 40: GAP begins on the next edge (counter saturated), then B is granted.
- Release and preempt on the same edge (tenure = 16, req goes 11 -> 10): single GAP of 2 ticks, then gnt = 10.
- Assert reset for 1 clk during OWN of B, then req = 11: A is granted first and outputs are blank for the clk following reset.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 3-digit display between sources A and B.
// Tenure is bounded in frame ticks, and a blank gap separates every owner change.
module display_arbiter #(
    parameter int MAX_TICKS = 16,
    parameter int GAP_TICKS = 2,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] req,
    input  logic [4:0] a_hex2,
    input  logic [4:0] a_hex1,
    input  logic [4:0] a_hex0,
    input  logic [2:0] a_dp,
    input  logic [4:0] b_hex2,
    input  logic [4:0] b_hex1,
    input  logic [4:0] b_hex0,
    input  logic [2:0] b_dp,
    output logic [1:0] gnt,
    output logic [4:0] hex2,
    output logic [4:0] hex1,
    output logic [4:0] hex0,
    output logic [2:0] dp,
    output logic [2:0] digit_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TICKS);
    localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state;
    logic             owner;
    logic             last_owner;
    logic [CNT_W-1:0] tenure;
    logic [CNT_W-1:0] gap_cnt;

    logic [CNT_W-1:0] tick_inc;
    logic             release_own;
    logic             preempt;
    logic             next_owner;
    logic [4:0]       own_hex2;
    logic [4:0]       own_hex1;
    logic [4:0]       own_hex0;
    logic [2:0]       own_dp;

    assign tick_inc = {{(CNT_W-1){1'b0}}, tick};

    // owner bit: 0 = A, 1 = B; on contention the source not served last wins
    always_comb begin
        next_owner  = req[1];
        if (req == 2'b11) begin
            next_owner = ~last_owner;
        end
        release_own = ~req[owner];
        preempt     = req[~owner] && (tenure == MAX_C);
    end

    always_comb begin
        own_hex2 = a_hex2;
        own_hex1 = a_hex1;
        own_hex0 = a_hex0;
        own_dp   = a_dp;
        if (owner) begin
            own_hex2 = b_hex2;
            own_hex1 = b_hex1;
            own_hex0 = b_hex0;
            own_dp   = b_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            tenure     <= '0;
            gap_cnt    <= '0;
            gnt        <= 2'b00;
            busy       <= 1'b0;
            hex2       <= '0;
            hex1       <= '0;
            hex0       <= '0;
            dp         <= '0;
            digit_en   <= '0;
        end else begin
            // display follows the state one clk behind the grant
            if (state == OWN) begin
                hex2     <= own_hex2;
                hex1     <= own_hex1;
                hex0     <= own_hex0;
                dp       <= own_dp;
                digit_en <= 3'b111;
            end else begin
                hex2     <= '0;
                hex1     <= '0;
                hex0     <= '0;
                dp       <= '0;
                digit_en <= '0;
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= OWN;
                        owner      <= next_owner;
                        last_owner <= next_owner;
                        tenure     <= tick_inc;
                        gnt        <= next_owner ? 2'b10 : 2'b01;
                        busy       <= 1'b1;
                    end
                end
                OWN: begin
                    if (release_own || preempt) begin
                        state   <= GAP;
                        gap_cnt <= tick_inc;
                        gnt     <= 2'b00;
                    end else if (tick && (tenure != MAX_C)) begin
                        tenure <= tenure + ONE_C;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_C) begin
                        if (|req) begin
                            state      <= OWN;
                            owner      <= next_owner;
                            last_owner <= next_owner;
                            tenure     <= tick_inc;
                            gnt        <= next_owner ? 2'b10 : 2'b01;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + tick_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: vector table, directed tenure/gap
// sequences, then random traffic against a reference model.
module tb_display_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] req;
    logic [4:0] a_hex2, a_hex1, a_hex0;
    logic [2:0] a_dp;
    logic [4:0] b_hex2, b_hex1, b_hex0;
    logic [2:0] b_dp;
    logic [1:0] gnt;
    logic [4:0] hex2, hex1, hex0;
    logic [2:0] dp;
    logic [2:0] digit_en;
    logic       busy;

    int errors = 0;
    int checks = 0;

    display_arbiter #(
        .MAX_TICKS(16),
        .GAP_TICKS(2),
        .CNT_W(5)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req),
        .a_hex2(a_hex2), .a_hex1(a_hex1), .a_hex0(a_hex0), .a_dp(a_dp),
        .b_hex2(b_hex2), .b_hex1(b_hex1), .b_hex0(b_hex0), .b_dp(b_dp),
        .gnt(gnt), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp(dp),
        .digit_en(digit_en), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tk;
        logic [1:0] rq;
        logic [4:0] ah0;
        logic [1:0] g;
        logic       b;
        logic [2:0] en;
        logic [4:0] h0;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rs, input logic tk, input logic [1:0] rq);
        reset = rs;
        tick  = tk;
        req   = rq;
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the display, how long, and what it shows.
    int          m_mode;   // 0 idle, 1 owned, 2 blank gap
    int          m_owner;  // 0 = A, 1 = B
    int          m_last;
    int          m_ticks;
    int          m_gap;
    logic [20:0] m_show;   // {hex2,hex1,hex0,dp,en}

    function automatic int choose(input logic [1:0] rq, input int last);
        if (rq == 2'b11) return 1 - last;
        return rq[1] ? 1 : 0;
    endfunction

    task automatic model_step(input logic rs, input logic tk, input logic [1:0] rq);
        int other;
        if (rs) begin
            m_mode = 0; m_last = 1; m_ticks = 0; m_gap = 0; m_show = '0;
            return;
        end
        if (m_mode == 1)
            m_show = (m_owner == 1) ? {b_hex2, b_hex1, b_hex0, b_dp, 3'b111}
                                    : {a_hex2, a_hex1, a_hex0, a_dp, 3'b111};
        else
            m_show = '0;
        other = 1 - m_owner;
        if (m_mode == 0) begin
            if (rq != 2'b00) begin
                m_owner = choose(rq, m_last); m_last = m_owner;
                m_mode = 1; m_ticks = int'(tk);
            end
        end else if (m_mode == 1) begin
            if (!rq[m_owner] || (rq[other] && m_ticks == 16)) begin
                m_mode = 2; m_gap = int'(tk);
            end else begin
                m_ticks = (m_ticks + int'(tk) > 16) ? 16 : m_ticks + int'(tk);
            end
        end else begin
            if (m_gap == 2) begin
                if (rq == 2'b00) m_mode = 0;
                else begin
                    m_owner = choose(rq, m_last); m_last = m_owner;
                    m_mode = 1; m_ticks = int'(tk);
                end
            end else begin
                m_gap = m_gap + int'(tk);
            end
        end
    endtask

    initial begin
        logic [1:0] rq;
        logic       rs, tk;
        reset = 1'b1; tick = 1'b0; req = 2'b00;
        a_hex2 = 5'd1; a_hex1 = 5'd2; a_hex0 = 5'd3; a_dp = 3'b001;
        b_hex2 = 5'd9; b_hex1 = 5'd10; b_hex0 = 5'd11; b_dp = 3'b100;

        tbl[0]  = '{1'b1, 1'b0, 2'b00, 5'd3, 2'b00, 1'b0, 3'b000, 5'd0};
        tbl[1]  = '{1'b0, 1'b0, 2'b01, 5'd3, 2'b01, 1'b1, 3'b000, 5'd0};
        tbl[2]  = '{1'b0, 1'b0, 2'b01, 5'd3, 2'b01, 1'b1, 3'b111, 5'd3};
        tbl[3]  = '{1'b0, 1'b0, 2'b01, 5'd7, 2'b01, 1'b1, 3'b111, 5'd7};
        tbl[4]  = '{1'b0, 1'b1, 2'b01, 5'd7, 2'b01, 1'b1, 3'b111, 5'd7};
        tbl[5]  = '{1'b0, 1'b0, 2'b00, 5'd7, 2'b00, 1'b1, 3'b111, 5'd7};
        tbl[6]  = '{1'b0, 1'b0, 2'b00, 5'd7, 2'b00, 1'b1, 3'b000, 5'd0};
        tbl[7]  = '{1'b0, 1'b1, 2'b00, 5'd7, 2'b00, 1'b1, 3'b000, 5'd0};
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 5'd7, 2'b00, 1'b1, 3'b000, 5'd0};
        tbl[9]  = '{1'b0, 1'b0, 2'b00, 5'd7, 2'b00, 1'b0, 3'b000, 5'd0};
        tbl[10] = '{1'b0, 1'b1, 2'b00, 5'd7, 2'b00, 1'b0, 3'b000, 5'd0};
        tbl[11] = '{1'b0, 1'b0, 2'b10, 5'd7, 2'b10, 1'b1, 3'b000, 5'd0};
        tbl[12] = '{1'b0, 1'b0, 2'b10, 5'd7, 2'b10, 1'b1, 3'b111, 5'd11};
        tbl[13] = '{1'b1, 1'b0, 2'b10, 5'd7, 2'b00, 1'b0, 3'b000, 5'd0};
        tbl[14] = '{1'b0, 1'b0, 2'b11, 5'd7, 2'b01, 1'b1, 3'b000, 5'd0};
        tbl[15] = '{1'b0, 1'b0, 2'b11, 5'd7, 2'b01, 1'b1, 3'b111, 5'd7};

        for (int i = 0; i < 16; i++) begin
            a_hex0 = tbl[i].ah0;
            cyc(tbl[i].rst, tbl[i].tk, tbl[i].rq);
            check($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tbl[i].g));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].b));
            check($sformatf("vec%0d en", i), 32'(digit_en), 32'(tbl[i].en));
            check($sformatf("vec%0d hex0", i), 32'(hex0), 32'(tbl[i].h0));
        end
        a_hex0 = 5'd3;

        // A owned last; reset must hand first contention back to A
        cyc(1'b1, 1'b0, 2'b11);
        check("rst_mid_own gnt", 32'(gnt), 32'(2'b00));
        check("rst_mid_own en", 32'(digit_en), 32'(3'b000));
        cyc(1'b0, 1'b0, 2'b11);
        check("rst_regrant gnt", 32'(gnt), 32'(2'b01));
        check("rst_regrant en", 32'(digit_en), 32'(3'b000));

        // preempt after 16 ticks of contention, 2-tick gap, then B
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b11);
        check("pre grantA", 32'(gnt), 32'(2'b01));
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 2'b11);
            check($sformatf("pre hold%0d", i), 32'(gnt), 32'(2'b01));
        end
        cyc(1'b0, 1'b0, 2'b11);
        check("pre gap gnt", 32'(gnt), 32'(2'b00));
        cyc(1'b0, 1'b1, 2'b11);
        check("pre gap1 en", 32'(digit_en), 32'(3'b000));
        cyc(1'b0, 1'b1, 2'b11);
        check("pre gap2 gnt", 32'(gnt), 32'(2'b00));
        check("pre gap2 en", 32'(digit_en), 32'(3'b000));
        cyc(1'b0, 1'b0, 2'b11);
        check("pre grantB", 32'(gnt), 32'(2'b10));
        cyc(1'b0, 1'b0, 2'b11);
        check("pre B hex", 32'({hex2, hex1, hex0, dp}),
              32'({5'd9, 5'd10, 5'd11, 3'b100}));

        // 40 ticks alone: no preemption; B arrival then preempts at once
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, 2'b01);
            check($sformatf("solo%0d", i), 32'(gnt), 32'(2'b01));
        end
        cyc(1'b0, 1'b0, 2'b11);
        check("solo gap", 32'(gnt), 32'(2'b00));
        cyc(1'b0, 1'b1, 2'b11);
        cyc(1'b0, 1'b1, 2'b11);
        check("solo gap end", 32'(gnt), 32'(2'b00));
        cyc(1'b0, 1'b0, 2'b11);
        check("solo grantB", 32'(gnt), 32'(2'b10));

        // release and preempt coincide: one gap, then B
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b11);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 2'b11);
        cyc(1'b0, 1'b0, 2'b10);
        check("both gap", 32'(gnt), 32'(2'b00));
        cyc(1'b0, 1'b1, 2'b10);
        cyc(1'b0, 1'b1, 2'b10);
        check("both gap end", 32'(gnt), 32'(2'b00));
        cyc(1'b0, 1'b0, 2'b10);
        check("both grantB", 32'(gnt), 32'(2'b10));

        // random traffic against the model
        rq = 2'b00;
        model_step(1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) rq = 2'($urandom);
            tk = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 299) == 0);
            a_hex2 = 5'($urandom); a_hex1 = 5'($urandom);
            a_hex0 = 5'($urandom); a_dp = 3'($urandom);
            b_hex2 = 5'($urandom); b_hex1 = 5'($urandom);
            b_hex0 = 5'($urandom); b_dp = 3'($urandom);
            model_step(rs, tk, rq);
            cyc(rs, tk, rq);
            check($sformatf("rnd%0d gnt", i), 32'(gnt),
                  (m_mode == 1) ? (32'd1 << m_owner) : 32'd0);
            check($sformatf("rnd%0d busy", i), 32'(busy), 32'(m_mode != 0));
            check($sformatf("rnd%0d show", i),
                  32'({hex2, hex1, hex0, dp, digit_en}), 32'(m_show));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
